// File: rtl/kfps2kb_pkg.sv
// Shared constants, table entry layout and the fixed Tandy remap for the
// KFPS2KB scancode remapper.
package kfps2kb_pkg;

  // Translation modes; the encoding 2'd3 is treated like MODE_PASS
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_TANDY = 2'd1;
  localparam logic [1:0] MODE_TABLE = 2'd2;

  // XT prefix bytes
  localparam logic [7:0] SC_PREFIX_E0 = 8'hE0;
  localparam logic [7:0] SC_PREFIX_E1 = 8'hE1;

  // map_wdata layout: {valid, e0_match, in_code[6:0], out_code[6:0]}
  localparam int MAP_VALID_BIT = 15;
  localparam int MAP_E0_BIT    = 14;
  localparam int MAP_IN_LSB    = 7;
  localparam int MAP_OUT_LSB   = 0;

  typedef struct packed {
    logic       valid;
    logic       e0_match;
    logic [6:0] in_code;
    logic [6:0] out_code;
  } map_entry_t;

  // Fixed Tandy remap of the 7-bit make code; the break bit is handled by the caller
  function automatic logic [6:0] tandy_map(input logic [6:0] code7, input logic e0);
    logic [6:0] res;
    res = code7;
    if (e0) begin
      case (code7)
        7'h48:   res = 7'h29;
        7'h4B:   res = 7'h2B;
        7'h50:   res = 7'h4A;
        7'h4D:   res = 7'h4E;
        7'h47:   res = 7'h58;
        7'h1C:   res = 7'h57;
        7'h57:   res = 7'h59;
        7'h58:   res = 7'h5A;
        default: res = code7;
      endcase
    end else begin
      case (code7)
        7'h4A:   res = 7'h53;
        7'h4E:   res = 7'h55;
        7'h53:   res = 7'h56;
        7'h57:   res = 7'h59;
        7'h58:   res = 7'h5A;
        default: res = code7;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/kfps2kb_sync_fifo.sv
// Show-ahead synchronous byte FIFO with level, sticky overflow and flush.
// A push to a full FIFO is dropped even if a pop happens in the same cycle.
module kfps2kb_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          overflow_r;
  logic          full_s;
  logic          empty_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_s    = (level_r == LW'(DEPTH));
  assign empty_s   = (level_r == {LW{1'b0}});
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;

  // Head byte presented combinationally; zero when nothing is queued
  always_comb begin
    rdata = {W{1'b0}};
    if (!empty_s) begin
      rdata = mem_r[rd_ptr_r];
    end else begin
      rdata = {W{1'b0}};
    end
  end

  // Storage array; written only on an accepted push
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (!flush && do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and sticky overflow; flush wins over push and pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (push && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign empty    = empty_s;
  assign full     = full_s;
  assign level    = level_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/kfps2kb_scancode_remapper.sv
// KFPS2KB scancode remapper: IRQ edge detect, E0/E1 prefix tracking,
// passthrough / Tandy / programmable-table translation and an output FIFO.
module kfps2kb_scancode_remapper
  import kfps2kb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int MAP_ENTRIES    = 16,
  parameter int FORWARD_PREFIX = 1,
  parameter int DEFAULT_MODE   = 1,
  localparam int AW = (MAP_ENTRIES > 1) ? $clog2(MAP_ENTRIES) : 1,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [7:0]    scancode,
  input  logic          keybord_irq,
  input  logic [1:0]    mode,
  input  logic          flush,
  input  logic          map_we,
  input  logic [AW-1:0] map_addr,
  input  logic [15:0]   map_wdata,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  logic       irq_d_r;
  logic       rise_s;
  logic [1:0] mode_q_r;
  logic       mode_chg_s;
  logic       e0_pend_r;
  logic [1:0] e1_cnt_r;
  map_entry_t table_r [MAP_ENTRIES];
  map_entry_t wr_entry_s;
  logic       tbl_hit_s;
  logic [6:0] tbl_out_s;
  logic [6:0] map7_s;
  logic [7:0] byte_out_s;
  logic       queue_s;
  logic       push_s;
  logic       empty_s;
  logic       full_s;

  assign rise_s     = keybord_irq & ~irq_d_r;
  assign mode_chg_s = (mode_q_r != mode);

  // IRQ level history for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_d_r <= 1'b0;
    end else begin
      irq_d_r <= keybord_irq;
    end
  end

  // Registered mode; a byte sees the mode that was present the cycle before its rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q_r <= 2'(DEFAULT_MODE);
    end else begin
      mode_q_r <= mode;
    end
  end

  // Prefix tracker; flush and a mode change discard any half-received sequence
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e0_pend_r <= 1'b0;
      e1_cnt_r  <= 2'd0;
    end else if (flush || mode_chg_s) begin
      e0_pend_r <= 1'b0;
      e1_cnt_r  <= 2'd0;
    end else if (rise_s) begin
      if (e1_cnt_r != 2'd0) begin
        e1_cnt_r <= e1_cnt_r - 2'd1;
      end else if (scancode == SC_PREFIX_E1) begin
        e1_cnt_r  <= 2'd2;
        e0_pend_r <= 1'b0;
      end else if (scancode == SC_PREFIX_E0) begin
        e0_pend_r <= 1'b1;
      end else begin
        e0_pend_r <= 1'b0;
      end
    end
  end

  // Unpack the write data into a table entry
  always_comb begin
    wr_entry_s          = '0;
    wr_entry_s.valid    = map_wdata[MAP_VALID_BIT];
    wr_entry_s.e0_match = map_wdata[MAP_E0_BIT];
    wr_entry_s.in_code  = map_wdata[MAP_IN_LSB +: 7];
    wr_entry_s.out_code = map_wdata[MAP_OUT_LSB +: 7];
  end

  // Programmable remap table; a write lands on the edge, so same-cycle lookups see old data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAP_ENTRIES; i++) begin
        table_r[i] <= '0;
      end
    end else if (map_we && (int'(map_addr) < MAP_ENTRIES)) begin
      table_r[map_addr] <= wr_entry_s;
    end
  end

  // Table lookup; the lowest-index hit wins, a miss passes the code through
  always_comb begin
    tbl_hit_s = 1'b0;
    tbl_out_s = scancode[6:0];
    for (int i = 0; i < MAP_ENTRIES; i++) begin
      if (!tbl_hit_s && table_r[i].valid &&
          (table_r[i].in_code == scancode[6:0]) &&
          (table_r[i].e0_match == e0_pend_r)) begin
        tbl_hit_s = 1'b1;
        tbl_out_s = table_r[i].out_code;
      end else begin
        tbl_hit_s = tbl_hit_s;
      end
    end
  end

  // Mode mux over the 7-bit make code
  always_comb begin
    map7_s = scancode[6:0];
    case (mode_q_r)
      MODE_TANDY: map7_s = tandy_map(scancode[6:0], e0_pend_r);
      MODE_TABLE: map7_s = tbl_out_s;
      default:    map7_s = scancode[6:0];
    endcase
  end

  // Decide what, if anything, the current byte contributes to the queue
  always_comb begin
    byte_out_s = scancode;
    queue_s    = 1'b0;
    if (e1_cnt_r != 2'd0) begin
      byte_out_s = scancode;
      queue_s    = 1'b1;
    end else if ((scancode == SC_PREFIX_E1) || (scancode == SC_PREFIX_E0)) begin
      byte_out_s = scancode;
      queue_s    = (FORWARD_PREFIX != 0);
    end else begin
      byte_out_s = {scancode[7], map7_s};
      queue_s    = 1'b1;
    end
  end

  assign push_s = rise_s & queue_s & ~flush;

  kfps2kb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push_s),
    .pop      (out_ready),
    .wdata    (byte_out_s),
    .rdata    (out_data),
    .empty    (empty_s),
    .full     (full_s),
    .level    (fifo_level),
    .overflow (overflow)
  );

  assign out_valid = ~empty_s;

endmodule

// File: tb/tb_kfps2kb_scancode_remapper.sv
// Scoreboard bench for kfps2kb_scancode_remapper: a default instance plus a
// second instance built with FORWARD_PREFIX=0.
module tb_kfps2kb_scancode_remapper;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  scancode;
  logic        keybord_irq;
  logic [1:0]  mode;
  logic        flush;
  logic        map_we;
  logic [3:0]  map_addr;
  logic [15:0] map_wdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;
  logic        overflow;

  logic [7:0]  scancode2;
  logic        irq2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [3:0]  fifo_level2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  kfps2kb_scancode_remapper dut (
    .clock(clock), .reset_n(reset_n), .scancode(scancode), .keybord_irq(keybord_irq),
    .mode(mode), .flush(flush), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  kfps2kb_scancode_remapper #(.FORWARD_PREFIX(0)) dut_np (
    .clock(clock), .reset_n(reset_n), .scancode(scancode2), .keybord_irq(irq2),
    .mode(mode), .flush(flush), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .fifo_level(fifo_level2), .overflow(overflow2)
  );

  // Present one byte with a one-cycle IRQ pulse; queue its expected output if any
  task automatic send(input logic [7:0] b, input bit expect_out, input logic [7:0] exp_b);
    @(negedge clock);
    scancode    = b;
    keybord_irq = 1'b1;
    if (expect_out) exp_q.push_back(exp_b);
    @(negedge clock);
    keybord_irq = 1'b0;
  endtask

  // Pop everything the scoreboard expects and compare in order
  task automatic drain(input string name);
    int guard;
    logic [7:0] exp_b;
    guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 64) begin
      if (out_valid === 1'b1) begin
        exp_b = exp_q.pop_front();
        checks++;
        if (out_data !== exp_b) begin
          errors++;
          $display("FAIL %s data: got %h expected %h", name, out_data, exp_b);
        end
      end
      @(negedge clock);
      guard++;
    end
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d bytes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s extra: out_valid got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; scancode = 8'h00; keybord_irq = 1'b0; mode = 2'd1; flush = 1'b0;
    map_we = 1'b0; map_addr = 4'd0; map_wdata = 16'h0000; out_ready = 1'b0;
    scancode2 = 8'h00; irq2 = 1'b0; out_ready2 = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({out_valid, out_data, fifo_level, overflow} !== 14'h0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%h l=%0d o=%b expected 0,00,0,0",
               out_valid, out_data, fifo_level, overflow);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_tandy();
    send(8'hE0, 1'b1, 8'hE0);
    send(8'h48, 1'b1, 8'h29);
    send(8'h48, 1'b1, 8'h48);
    send(8'hE0, 1'b1, 8'hE0);
    send(8'hC8, 1'b1, 8'hA9);
    send(8'h4A, 1'b1, 8'h53);
    checks++;
    if (fifo_level !== 4'd6) begin
      errors++;
      $display("FAIL tandy level: got %0d expected 6", fifo_level);
    end
    drain("tandy");
  endtask

  task automatic test_e1_pause();
    send(8'hE1, 1'b1, 8'hE1);
    send(8'h4A, 1'b1, 8'h4A);
    send(8'h4E, 1'b1, 8'h4E);
    send(8'h4A, 1'b1, 8'h53);
    drain("e1_pause");
  endtask

  task automatic test_table();
    @(negedge clock);
    mode = 2'd2;
    map_we = 1'b1; map_addr = 4'd0; map_wdata = {1'b1, 1'b0, 7'h3A, 7'h1D};
    @(negedge clock);
    map_addr = 4'd1; map_wdata = {1'b1, 1'b0, 7'h3A, 7'h2A};
    @(negedge clock);
    map_we = 1'b0;
    send(8'h3A, 1'b1, 8'h1D);
    send(8'hBA, 1'b1, 8'h9D);
    send(8'h1E, 1'b1, 8'h1E);
    send(8'hE0, 1'b1, 8'hE0);
    send(8'h3A, 1'b1, 8'h3A);
    drain("table");
    mode = 2'd1;
    @(negedge clock);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), (i <= 8), 8'(i));
    end
    checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow fill: got l=%0d o=%b expected 8,1", fifo_level, overflow);
    end
    drain("overflow");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow sticky: got %b expected 1", overflow);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow flush: got %b expected 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    send(8'h21, 1'b1, 8'h21);
    send(8'h22, 1'b1, 8'h22);
    @(negedge clock);
    scancode = 8'h23; keybord_irq = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'h23);
    exp_b = exp_q.pop_front();
    checks++;
    if (out_data !== exp_b) begin
      errors++;
      $display("FAIL b2b head: got %h expected %h", out_data, exp_b);
    end
    @(negedge clock);
    keybord_irq = 1'b0; out_ready = 1'b0;
    checks++;
    if (fifo_level !== 4'd2) begin
      errors++;
      $display("FAIL b2b level: got %0d expected 2", fifo_level);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    send(8'h10, 1'b1, 8'h10);
    send(8'h11, 1'b1, 8'h11);
    send(8'hE0, 1'b1, 8'hE0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b l=%0d expected 0,0", out_valid, fifo_level);
    end
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    send(8'h48, 1'b1, 8'h48);
    drain("reset_mid");
  endtask

  task automatic test_flush_and_noprefix();
    @(negedge clock);
    flush = 1'b1; scancode = 8'h10; keybord_irq = 1'b1;
    @(negedge clock);
    flush = 1'b0; keybord_irq = 1'b0;
    @(negedge clock);
    checks++;
    if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_rise: got l=%0d v=%b expected 0,0", fifo_level, out_valid);
    end
    @(negedge clock);
    scancode2 = 8'hE0; irq2 = 1'b1;
    @(negedge clock);
    irq2 = 1'b0;
    checks++;
    if (fifo_level2 !== 4'd0) begin
      errors++;
      $display("FAIL noprefix e0: got level %0d expected 0", fifo_level2);
    end
    @(negedge clock);
    scancode2 = 8'h48; irq2 = 1'b1;
    @(negedge clock);
    irq2 = 1'b0;
    checks++;
    if (fifo_level2 !== 4'd1 || out_data2 !== 8'h29) begin
      errors++;
      $display("FAIL noprefix 48: got l=%0d d=%h expected 1,29", fifo_level2, out_data2);
    end
  endtask

  initial begin
    test_reset();
    test_tandy();
    test_e1_pause();
    test_table();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_flush_and_noprefix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
